// File: rtl/simon_seq_player.sv
// Replays the level's pseudo-random colour sequence by reloading and stepping the shared LFSR,
// framing each colour in timed tone-on / silence windows. Optional abort input: SIMON_SEQ_PLAYER_ABORT_EN.
module simon_seq_player #(
    parameter int TICKS_ON  = 8,
    parameter int TICKS_GAP = 4,
    parameter int LEN_W     = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      seed,
    input  logic [LEN_W-1:0] length,
    input  logic             tick,
    input  logic [31:0]      lfsr_out,
`ifdef SIMON_SEQ_PLAYER_ABORT_EN
    input  logic             abort,
`endif
    output logic             lfsr_load,
    output logic [31:0]      lfsr_load_value,
    output logic             lfsr_enable,
    output logic [1:0]       color,
    output logic             color_valid,
    output logic [LEN_W-1:0] step_idx,
    output logic             busy,
    output logic             done
);

    localparam int TICK_MAX = (TICKS_ON > TICKS_GAP) ? TICKS_ON : TICKS_GAP;
    localparam int CNT_W    = $clog2(TICK_MAX + 1);
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(TICKS_ON - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(TICKS_GAP - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        ADVANCE = 3'd2,
        SHOW    = 3'd3,
        GAP     = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t             state, state_d;
    logic [31:0]        seed_q, seed_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   step_q, step_d;
    logic [CNT_W-1:0]   tick_cnt, cnt_d;
    logic               lfsr_unused;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            seed_q   <= '0;
            len_q    <= '0;
            step_q   <= '0;
            tick_cnt <= '0;
        end else begin
            state    <= state_d;
            seed_q   <= seed_d;
            len_q    <= len_d;
            step_q   <= step_d;
            tick_cnt <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        seed_d  = seed_q;
        len_d   = len_q;
        step_d  = step_q;
        cnt_d   = tick_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    step_d = '0;
                    // An empty sequence finishes without ever touching the LFSR.
                    if (length != '0) begin
                        seed_d  = seed;
                        len_d   = length;
                        state_d = LOAD;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            LOAD:    state_d = ADVANCE;
            ADVANCE: begin
                state_d = SHOW;
                cnt_d   = '0;
            end
            SHOW: begin
                if (tick) begin
                    if (tick_cnt == ON_LAST) begin
                        cnt_d   = '0;
                        state_d = GAP;
                    end else begin
                        cnt_d = tick_cnt + CNT_W'(1);
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (tick_cnt == GAP_LAST) begin
                        cnt_d = '0;
                        if (step_q == len_q - LEN_W'(1)) begin
                            state_d = DONE;
                        end else begin
                            step_d  = step_q + LEN_W'(1);
                            state_d = ADVANCE;
                        end
                    end else begin
                        cnt_d = tick_cnt + CNT_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef SIMON_SEQ_PLAYER_ABORT_EN
        if (abort && state != IDLE) begin
            state_d = IDLE;
            step_d  = '0;
            cnt_d   = '0;
        end
`endif
    end

    // Colour is a pass-through; the LFSR is held steady for the whole SHOW window.
    assign lfsr_load       = (state == LOAD);
    assign lfsr_enable     = (state == ADVANCE);
    assign lfsr_load_value = seed_q;
    assign color_valid     = (state == SHOW);
    assign color           = (state == SHOW) ? lfsr_out[1:0] : 2'b00;
    assign step_idx        = step_q;
    assign busy            = (state != IDLE);
    assign done            = (state == DONE);
    assign lfsr_unused     = ^lfsr_out[31:2];

endmodule

// File: tb/tb_simon_seq_player.sv
// Self-checking bench for simon_seq_player: LFSR stand-in, behavioural playback model and
// per-cycle compare, plus directed latency/colour/reset checks and randomized playbacks.
module tb_simon_seq_player;

    localparam int ON  = 8;
    localparam int GAP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] seed = '0;
    logic [5:0]  length = '0;
    logic        tick = 1'b0;
    logic [31:0] lfsr_q = '0;
`ifdef SIMON_SEQ_PLAYER_ABORT_EN
    logic        abort = 1'b0;
`endif
    logic        lfsr_load, lfsr_enable, color_valid, busy, done;
    logic [31:0] lfsr_load_value;
    logic [1:0]  color;
    logic [5:0]  step_idx;

    int checks = 0;
    int errors = 0;
    int tick_mode = 0;
    int cyc = 0;
    bit checking = 0;

    simon_seq_player #(.TICKS_ON(ON), .TICKS_GAP(GAP), .LEN_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .length(length),
        .tick(tick), .lfsr_out(lfsr_q),
`ifdef SIMON_SEQ_PLAYER_ABORT_EN
        .abort(abort),
`endif
        .lfsr_load(lfsr_load), .lfsr_load_value(lfsr_load_value), .lfsr_enable(lfsr_enable),
        .color(color), .color_valid(color_valid), .step_idx(step_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Shift-left LFSR stand-in; for small states the feedback reduces to bit1^bit0.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    function automatic logic [31:0] lfsr_after(input logic [31:0] s, input int n);
        logic [31:0] v = s;
        for (int i = 0; i < n; i++) v = lfsr_step(v);
        return v;
    endfunction

    always @(posedge clk) begin
        if (lfsr_load)        lfsr_q <= lfsr_load_value;
        else if (lfsr_enable) lfsr_q <= lfsr_step(lfsr_q);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Playback model: setup countdown (2=load, 1=advance), ticks counted within the current step.
    bit          m_busy = 0, m_done = 0;
    int          m_pre = 0, m_t = 0, m_k = 0, m_len = 0;
    logic [31:0] m_seed = '0;

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_pre = 0; m_t = 0; m_k = 0; m_len = 0; m_seed = '0;
        end
`ifdef SIMON_SEQ_PLAYER_ABORT_EN
        else if (abort && m_busy) begin
            m_busy = 0; m_done = 0; m_pre = 0; m_t = 0; m_k = 0;
        end
`endif
        else if (m_done) begin
            m_done = 0; m_busy = 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1; m_k = 0;
                if (length == 0) m_done = 1;
                else begin m_seed = seed; m_len = int'(length); m_pre = 2; m_t = 0; end
            end
        end else if (m_pre != 0) begin
            m_pre--; m_t = 0;
        end else if (tick) begin
            m_t++;
            if (m_t == ON + GAP) begin
                m_t = 0;
                if (m_k == m_len - 1) m_done = 1;
                else begin m_k++; m_pre = 1; end
            end
        end
    end

    initial forever begin
        logic        active, e_cv;
        logic [31:0] ev;
        logic [1:0]  e_col;
        @(negedge clk);
        if (checking) begin
            active = m_busy && !m_done;
            e_cv   = active && m_pre == 0 && m_t < ON;
            ev     = lfsr_after(m_seed, m_k + 1);
            e_col  = e_cv ? ev[1:0] : 2'b00;
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("lfsr_load", 32'(lfsr_load), 32'(active && m_pre == 2));
            chk("lfsr_enable", 32'(lfsr_enable), 32'(active && m_pre == 1));
            chk("lfsr_load_value", lfsr_load_value, m_seed);
            chk("color_valid", 32'(color_valid), 32'(e_cv));
            chk("color", 32'(color), 32'(e_col));
            chk("step_idx", 32'(step_idx), m_k);
        end
    end

    // Tick source and observation monitor, both on the falling edge.
    logic [1:0] cols[$];
    int done_cnt = 0;
    bit prev_cv = 0;
    initial forever begin
        @(negedge clk);
        cyc++;
        if (color_valid && !prev_cv) cols.push_back(color);
        if (done) done_cnt++;
        prev_cv = color_valid;
        tick = (tick_mode == 0) ? cyc[0] : ($urandom_range(2) == 0);
    end

    task automatic do_start(input logic [31:0] s, input int len);
        seed = s; length = 6'(len); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input bit spam);
        int n = 0;
        while (busy && n < budget) begin
            if (spam) begin
                start = ($urandom_range(3) == 0);
                seed = $urandom; length = 6'($urandom_range(5));
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles, expected 0", budget);
        end
    endtask

    task automatic wait_cond_step(input int k, input bit want_cv, input int budget);
        int n = 0;
        while (!(busy && !done && int'(step_idx) == k && color_valid == want_cv
                 && !lfsr_enable && !lfsr_load) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL wait_step: step %0d not reached within %0d cycles, expected reached", k, budget);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checking = 1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_load", 32'(lfsr_load), 0);
        chk("rst_load_value", lfsr_load_value, 0);
        chk("rst_enable", 32'(lfsr_enable), 0);
        chk("rst_color_valid", 32'(color_valid), 0);
        chk("rst_step_idx", 32'(step_idx), 0);
        chk("model_pin_1", lfsr_after(32'h1, 1), 32'h3);
        chk("model_pin_4", lfsr_after(32'h1, 4), 32'h1B);

        // Directed: seed 1, length 4, tick every 2 cycles; latency pinned cycle by cycle.
        tick_mode = 0; cols.delete(); done_cnt = 0;
        do_start(32'h1, 4);
        chk("lat_t1_load", 32'(lfsr_load), 1);
        chk("lat_t1_value", lfsr_load_value, 32'h1);
        chk("lat_t1_enable", 32'(lfsr_enable), 0);
        @(negedge clk);
        chk("lat_t2_load", 32'(lfsr_load), 0);
        chk("lat_t2_enable", 32'(lfsr_enable), 1);
        chk("lat_t2_cv", 32'(color_valid), 0);
        @(negedge clk);
        chk("lat_t3_cv", 32'(color_valid), 1);
        chk("lat_t3_color", 32'(color), 3);
        wait_idle(2000, 0);
        chk("dir_ncols", cols.size(), 4);
        if (cols.size() == 4) begin
            chk("dir_col0", 32'(cols[0]), 3);
            chk("dir_col1", 32'(cols[1]), 2);
            chk("dir_col2", 32'(cols[2]), 1);
            chk("dir_col3", 32'(cols[3]), 3);
        end
        chk("dir_done_pulses", done_cnt, 1);

        // length 0: straight to DONE, no LFSR activity.
        done_cnt = 0;
        do_start(32'hDEAD_BEEF, 0);
        chk("len0_done", 32'(done), 1);
        chk("len0_load", 32'(lfsr_load), 0);
        chk("len0_enable", 32'(lfsr_enable), 0);
        @(negedge clk);
        chk("len0_done_fall", 32'(done), 0);
        chk("len0_busy_fall", 32'(busy), 0);
        chk("len0_done_pulses", done_cnt, 1);

        // Starts during a length-3 playback are ignored; then a fresh length-1 run.
        tick_mode = 1;
        do_start($urandom, 3);
        wait_idle(3000, 1);
        cols.delete();
        do_start(32'h1, 1);
        wait_idle(2000, 0);
        chk("restart_ncols", cols.size(), 1);
        if (cols.size() == 1) chk("restart_col", 32'(cols[0]), 3);

        // Reset during SHOW of step 2, then replay from step 0.
        tick_mode = 0;
        do_start(32'h1, 4);
        wait_cond_step(2, 1, 2000);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_cv", 32'(color_valid), 0);
        chk("midrst_step", 32'(step_idx), 0);
        chk("midrst_value", lfsr_load_value, 0);
        cols.delete();
        do_start(32'h1, 2);
        wait_idle(2000, 0);
        chk("replay_ncols", cols.size(), 2);
        if (cols.size() == 2) chk("replay_col0", 32'(cols[0]), 3);

`ifdef SIMON_SEQ_PLAYER_ABORT_EN
        done_cnt = 0;
        do_start(32'h1, 4);
        wait_cond_step(1, 0, 2000);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_step", 32'(step_idx), 0);
        repeat (20) @(negedge clk);
        chk("abort_no_done", done_cnt, 0);
`endif

        // Randomized playbacks with start spam and occasional resets.
        for (int it = 0; it < 16; it++) begin
            tick_mode = int'($urandom_range(1));
            do_start($urandom, int'($urandom_range(5)));
            if ($urandom_range(4) == 0) begin
                repeat ($urandom_range(60)) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            wait_idle(3000, 1);
            repeat ($urandom_range(3)) @(negedge clk);
        end

        @(negedge clk);
        checking = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
